adam_periph_uart_rx: RTL and testbench
======================================

// Module: adam_periph_uart_rx
// PURPOSE
//  UART receiver; counterpart of the peripheral's UART transmitter, sharing its
//  runtime frame configuration. Oversamples the async rx line and recovers
//  start/data/parity/stop bits, data LSB first.
//  Presents each word on a valid/ready output with parity/frame/overrun status.
//  Same pause extension as TX: while pause.req && pause.ack, config may change.
// PARAMETERS
//  DATA_WIDTH  32  width of data/baud_rate words; data_length must be <= DATA_WIDTH
// PORTS
//  seq.clk         in   1   clock (ADAM_SEQ.Slave seq)
//  seq.rst         in   1   reset: asynchronous, active-low
//  pause.req/ack   slave 1/1  ADAM_PAUSE.Slave pause
//  parity_select   in   1   0 = even, 1 = odd parity
//  parity_control  in   1   1 = parity bit present
//  data_length     in   4   data bits per frame
//  stop_bits       in   1   0 = one stop bit, 1 = two
//  baud_rate       in   DW  bit period = baud_rate+1 clk cycles
//  data            out  DW  received word, right-aligned, upper bits zero
//  data_valid      out  1   word available
//  data_ready      in   1   consumer accepts
//  parity_error    out  1   parity mismatch for word on data (valid w/ data_valid)
//  frame_error     out  1   a stop bit sampled 0 (valid w/ data_valid)
//  overrun         out  1   one-cycle pulse: completed frame dropped
//  rx              in   1   serial line, asynchronous, idles high
// BEHAVIOUR
//  Reset: data=0, data_valid=0, parity_error=0, frame_error=0, overrun=0,
//   pause.ack=1, FSM=IDLE, synchroniser flops=1. Reset mid-frame aborts it.
//  rx passes through a 2-flop synchroniser (rx_s); edge detect uses rx_s and
//   a third flop rx_q; all timing below is relative to rx_s.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: if !pause.req && !pause.ack && rx_q=1 && rx_s=0 -> START, clk_count=0.
//     Otherwise pause.ack <= pause.req. No start detection while ack=1.
//   START: at clk_count == baud_rate>>1 sample; 0 -> DATA (clk_count=0);
//     1 -> false start, back to IDLE, nothing reported.
//   DATA/PARITY/STOP: sample when clk_count == baud_rate (mid-bit), then
//     clk_count=0; otherwise clk_count++.
//   DATA: shift sample in; bit_count++; after data_length bits -> PARITY if
//     parity_control else STOP. data_length=0 skips DATA.
//   PARITY: perr = sample ^ (XOR of data bits) ^ parity_select.
//   STOP: sample stop_bits+1 bits; any 0 sets ferr. Leave STOP right after last
//     sample (mid-bit), so the next start edge is never missed.
//  Completion (cycle of last stop sample, registered next edge):
//   if !data_valid || data_ready: data, parity_error, frame_error load;
//     data_valid=1. Simultaneous accept + completion: old word retires, new loads.
//   else: new frame discarded, overrun=1 for one cycle, old word untouched.
//  Output handshake: transfer on data_valid && data_ready; data_valid drops
//   next cycle unless new word loads. data/flags stable while valid && !ready.
//  Config inputs sampled live; only legal to change while paused (ack=1).
//  pause.req during a frame: frame completes normally, ack asserts in IDLE.
//   Deasserting req drops ack next IDLE cycle.
//  Counters DATA_WIDTH wide, never wrap (bounded by baud_rate).
// STRUCTURE
//  adam_periph_uart_pkg: typedef enum uart_rx_state_t {IDLE, START, DATA,
//   PARITY, STOP}; shared with TX if it moves to an explicit FSM.
//  Sub-module adam_periph_uart_sync: 2-flop synchroniser, reset value 1,
//   async active-low reset; reusable for other async peripheral inputs.
// TESTING
//  Reset, rx=1, no pause.req -> ack=1, valid=0; drop pause.req -> ack=0 in 1 cycle.
//  baud_rate=15, 8N1, send 0xA5 -> data=0x000000A5, valid=1, both errors 0.
//  8E1 (parity_select=0) wrong parity bit on 0x3C -> data=0x3C, parity_error=1.
//  2 stop bits, 2nd stop driven 0 -> frame_error=1; next 0x55 -> frame_error=0.
//  rx low 4 cycles (baud_rate=15) -> false start, no valid; next 0x12 correct.
//  data_ready=0, send 0x11 then 0x22 -> data stays 0x11, overrun pulses 1 cycle.
//  Extra: TX->RX loopback, random configs, 7O2, data_length=5.

Source files
------------

// File: rtl/adam_periph_uart_pkg.sv
// Shared types for the peripheral UART (receiver now, transmitter later).
package adam_periph_uart_pkg;

  localparam int unsigned UART_DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/adam_periph_uart_rx_if.sv
// Sequencing (clock/reset) and pause-handshake interfaces used by the UART.
interface ADAM_SEQ;
  logic clk;
  logic rst;

  modport Master (output clk, output rst);
  modport Slave  (input clk, input rst);
endinterface

interface ADAM_PAUSE;
  logic req;
  logic ack;

  modport Master (output req, input ack);
  modport Slave  (input req, output ack);
endinterface

// File: rtl/adam_periph_uart_sync.sv
// Two-flop synchroniser for asynchronous inputs; both flops reset to 1 so an
// idle-high line does not produce a spurious edge when reset is released.
module adam_periph_uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adam_periph_uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery with a
// valid/ready output holding one word plus parity/frame/overrun status.
module adam_periph_uart_rx
  import adam_periph_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DEFAULT_DATA_WIDTH
) (
  ADAM_SEQ.Slave                 seq,
  ADAM_PAUSE.Slave               pause,
  input  logic                   parity_select,
  input  logic                   parity_control,
  input  logic [3:0]             data_length,
  input  logic                   stop_bits,
  input  logic [DATA_WIDTH-1:0]  baud_rate,
  output logic [DATA_WIDTH-1:0]  data,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   parity_error,
  output logic                   frame_error,
  output logic                   overrun,
  input  logic                   rx
);

  localparam int unsigned IW = $clog2(DATA_WIDTH);

  uart_rx_state_t        state;
  logic                  rx_s;
  logic                  rx_q;
  logic [DATA_WIDTH-1:0] clk_count;
  logic [DATA_WIDTH-1:0] bit_count;
  logic [DATA_WIDTH-1:0] data_buf;
  logic                  parity_acc;
  logic                  perr;
  logic                  ferr;
  logic                  stop_idx;
  logic [DATA_WIDTH-1:0] len_ext;

  assign len_ext = {{(DATA_WIDTH-4){1'b0}}, data_length};

  adam_periph_uart_sync u_sync (
    .clk   (seq.clk),
    .rst_n (seq.rst),
    .d     (rx),
    .q     (rx_s)
  );

  // Third flop behind the synchroniser, used only for falling-edge detection.
  always_ff @(posedge seq.clk or negedge seq.rst) begin
    if (!seq.rst) begin
      rx_q <= 1'b1;
    end else begin
      rx_q <= rx_s;
    end
  end

  // Frame FSM with registered output word, status flags and pause handshake.
  always_ff @(posedge seq.clk or negedge seq.rst) begin
    if (!seq.rst) begin
      state        <= IDLE;
      clk_count    <= '0;
      bit_count    <= '0;
      data_buf     <= '0;
      parity_acc   <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      stop_idx     <= 1'b0;
      data         <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
      pause.ack    <= 1'b1;
    end else begin
      overrun <= 1'b0;
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!pause.req && !pause.ack && rx_q && !rx_s) begin
            state     <= START;
            clk_count <= '0;
          end else begin
            pause.ack <= pause.req;
          end
        end

        START: begin
          if (clk_count == (baud_rate >> 1)) begin
            clk_count <= '0;
            if (!rx_s) begin
              bit_count  <= '0;
              data_buf   <= '0;
              parity_acc <= 1'b0;
              perr       <= 1'b0;
              ferr       <= 1'b0;
              stop_idx   <= 1'b0;
              if (data_length == 4'd0) begin
                state <= parity_control ? PARITY : STOP;
              end else begin
                state <= DATA;
              end
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_count <= clk_count + DATA_WIDTH'(1);
          end
        end

        DATA: begin
          if (clk_count == baud_rate) begin
            clk_count                 <= '0;
            data_buf[bit_count[IW-1:0]] <= rx_s;
            parity_acc                <= parity_acc ^ rx_s;
            bit_count                 <= bit_count + DATA_WIDTH'(1);
            if ((bit_count + DATA_WIDTH'(1)) == len_ext) begin
              state <= parity_control ? PARITY : STOP;
            end
          end else begin
            clk_count <= clk_count + DATA_WIDTH'(1);
          end
        end

        PARITY: begin
          if (clk_count == baud_rate) begin
            clk_count <= '0;
            perr      <= rx_s ^ parity_acc ^ parity_select;
            state     <= STOP;
          end else begin
            clk_count <= clk_count + DATA_WIDTH'(1);
          end
        end

        STOP: begin
          if (clk_count == baud_rate) begin
            clk_count <= '0;
            if (stop_idx == stop_bits) begin
              state <= IDLE;
              if (!data_valid || data_ready) begin
                data         <= data_buf;
                parity_error <= perr;
                frame_error  <= ferr | ~rx_s;
                data_valid   <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              stop_idx <= 1'b1;
              ferr     <= ferr | ~rx_s;
            end
          end else begin
            clk_count <= clk_count + DATA_WIDTH'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adam_periph_uart_rx.sv
// Self-checking bench for adam_periph_uart_rx: the bench acts as the serial
// transmitter and predicts each received word from the frame it sent.
module tb_adam_periph_uart_rx;

  localparam int DW = 32;

  ADAM_SEQ   seq ();
  ADAM_PAUSE pause ();

  logic          parity_select;
  logic          parity_control;
  logic [3:0]    data_length;
  logic          stop_bits;
  logic [DW-1:0] baud_rate;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          data_ready;
  logic          parity_error;
  logic          frame_error;
  logic          overrun;
  logic          rx;

  int total = 0;
  int bad = 0;
  int overrun_cnt = 0;

  adam_periph_uart_rx #(.DATA_WIDTH(DW)) dut (
    .seq            (seq.Slave),
    .pause          (pause.Slave),
    .parity_select  (parity_select),
    .parity_control (parity_control),
    .data_length    (data_length),
    .stop_bits      (stop_bits),
    .baud_rate      (baud_rate),
    .data           (data),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .parity_error   (parity_error),
    .frame_error    (frame_error),
    .overrun        (overrun),
    .rx             (rx)
  );

  // Free-running clock.
  initial seq.clk = 1'b0;
  always #5 seq.clk = ~seq.clk;

  // Count cycles on which the overrun pulse is high.
  always @(negedge seq.clk) if (overrun === 1'b1) overrun_cnt++;

  // Guard against a hung run.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Serialise one frame with the current configuration; optionally corrupt
  // the parity bit and choose each stop bit level (bit 0 is sent first).
  task automatic send_frame(input logic [DW-1:0] word, input bit flip_par, input bit [1:0] stop_val);
    int per;
    logic [DW-1:0] mask;
    logic p;
    per  = int'(baud_rate) + 1;
    mask = (DW'(1) << data_length) - DW'(1);
    rx = 1'b1;
    repeat (2 * per) @(negedge seq.clk);
    rx = 1'b0;
    repeat (per) @(negedge seq.clk);
    for (int i = 0; i < int'(data_length); i++) begin
      rx = word[i];
      repeat (per) @(negedge seq.clk);
    end
    if (parity_control) begin
      p  = (^(word & mask)) ^ parity_select ^ flip_par;
      rx = p;
      repeat (per) @(negedge seq.clk);
    end
    for (int s = 0; s <= int'(stop_bits); s++) begin
      rx = stop_val[s];
      repeat (per) @(negedge seq.clk);
    end
    rx = 1'b1;
    repeat (3) @(negedge seq.clk);
  endtask

  // Pause, change the frame configuration, then resume.
  task automatic set_config(input int br, input int len, input bit pc, input bit ps, input bit sb);
    int n;
    pause.req = 1'b1;
    n = 0;
    while (pause.ack !== 1'b1 && n < 1000) begin
      @(negedge seq.clk);
      n++;
    end
    check_output("pause_ack_rise", DW'(pause.ack), DW'(1));
    baud_rate      = DW'(br);
    data_length    = 4'(len);
    parity_control = pc;
    parity_select  = ps;
    stop_bits      = sb;
    @(negedge seq.clk);
    pause.req = 1'b0;
    repeat (2) @(negedge seq.clk);
  endtask

  // Consume the current word and confirm valid retires.
  task automatic accept_word(input string tag);
    data_ready = 1'b1;
    @(negedge seq.clk);
    data_ready = 1'b0;
    check_output(tag, DW'(data_valid), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] word;
    logic [DW-1:0] mask;
    bit flip;
    bit [1:0] sv;
    int snap;
    int br;
    int len;
    bit pc;
    bit ps;
    bit sb;

    seq.rst        = 1'b0;
    pause.req      = 1'b1;
    rx             = 1'b1;
    data_ready     = 1'b0;
    baud_rate      = DW'(15);
    data_length    = 4'd8;
    parity_control = 1'b0;
    parity_select  = 1'b0;
    stop_bits      = 1'b0;
    repeat (3) @(negedge seq.clk);

    check_output("rst_ack", DW'(pause.ack), DW'(1));
    check_output("rst_valid", DW'(data_valid), DW'(0));
    check_output("rst_data", data, DW'(0));
    check_output("rst_errs", DW'({parity_error, frame_error, overrun}), DW'(0));

    seq.rst = 1'b1;
    repeat (2) @(negedge seq.clk);
    check_output("ack_hold", DW'(pause.ack), DW'(1));
    pause.req = 1'b0;
    @(negedge seq.clk);
    check_output("ack_drop", DW'(pause.ack), DW'(0));

    // 8N1, 0xA5
    send_frame(DW'(32'hA5), 1'b0, 2'b11);
    check_output("a5_valid", DW'(data_valid), DW'(1));
    check_output("a5_data", data, DW'(32'hA5));
    check_output("a5_errs", DW'({parity_error, frame_error}), DW'(0));
    repeat (5) @(negedge seq.clk);
    check_output("a5_hold", data, DW'(32'hA5));
    accept_word("a5_accept");

    // 8E1 with a corrupted parity bit
    set_config(15, 8, 1'b1, 1'b0, 1'b0);
    send_frame(DW'(32'h3C), 1'b1, 2'b11);
    check_output("3c_data", data, DW'(32'h3C));
    check_output("3c_perr", DW'(parity_error), DW'(1));
    check_output("3c_ferr", DW'(frame_error), DW'(0));
    accept_word("3c_accept");

    // Two stop bits, second one low
    set_config(15, 8, 1'b0, 1'b0, 1'b1);
    send_frame(DW'(32'h99), 1'b0, 2'b01);
    check_output("ferr_data", data, DW'(32'h99));
    check_output("ferr_set", DW'(frame_error), DW'(1));
    accept_word("ferr_accept");
    send_frame(DW'(32'h55), 1'b0, 2'b11);
    check_output("55_data", data, DW'(32'h55));
    check_output("55_ferr", DW'(frame_error), DW'(0));
    accept_word("55_accept");

    // False start: low pulse shorter than half a bit
    set_config(15, 8, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (4) @(negedge seq.clk);
    rx = 1'b1;
    repeat (48) @(negedge seq.clk);
    check_output("false_start", DW'(data_valid), DW'(0));
    send_frame(DW'(32'h12), 1'b0, 2'b11);
    check_output("12_valid", DW'(data_valid), DW'(1));
    check_output("12_data", data, DW'(32'h12));
    accept_word("12_accept");

    // Overrun: second word arrives while first is still held
    send_frame(DW'(32'h11), 1'b0, 2'b11);
    snap = overrun_cnt;
    send_frame(DW'(32'h22), 1'b0, 2'b11);
    check_output("ovr_data", data, DW'(32'h11));
    check_output("ovr_valid", DW'(data_valid), DW'(1));
    check_output("ovr_pulse", DW'(overrun_cnt - snap), DW'(1));
    accept_word("ovr_accept");

    // 7O2
    set_config(11, 7, 1'b1, 1'b1, 1'b1);
    send_frame(DW'(32'hDA), 1'b0, 2'b11);
    check_output("7o2_data", data, DW'(32'h5A));
    check_output("7o2_errs", DW'({parity_error, frame_error}), DW'(0));
    accept_word("7o2_accept");

    // Five data bits, even parity
    set_config(9, 5, 1'b1, 1'b0, 1'b0);
    send_frame(DW'(32'hF3), 1'b0, 2'b11);
    check_output("len5_data", data, DW'(32'h13));
    check_output("len5_perr", DW'(parity_error), DW'(0));
    accept_word("len5_accept");

    // Randomised frames against the frame-level model
    for (int k = 0; k < 12; k++) begin
      br  = int'($urandom_range(7, 20));
      len = int'($urandom_range(1, 12));
      pc  = 1'($urandom_range(0, 1));
      ps  = 1'($urandom_range(0, 1));
      sb  = 1'($urandom_range(0, 1));
      set_config(br, len, pc, ps, sb);
      word = DW'($urandom);
      flip = 1'($urandom_range(0, 1));
      sv   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      send_frame(word, flip, sv);
      mask = (DW'(1) << len) - DW'(1);
      check_output("rnd_valid", DW'(data_valid), DW'(1));
      check_output("rnd_data", data, word & mask);
      check_output("rnd_perr", DW'(parity_error), DW'(pc & flip));
      check_output("rnd_ferr", DW'(frame_error), DW'(sb ? !(sv[0] && sv[1]) : !sv[0]));
      accept_word("rnd_accept");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
